// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  regfile_mp_if : write/read/dump bus of the two-write-port register file
//  Rev 1.0
// ============================================================================
interface regfile_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic            we0, we1;
    logic [AW-1:0]   wa0, wa1;
    logic [DW-1:0]   wd0, wd1;
    logic [DW/8-1:0] be0, be1;
    logic [AW-1:0]   ra0, ra1;
    logic [DW-1:0]   rd0, rd1;
    logic            clr;
    logic            dump_start;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_addr;
    logic [DW-1:0]   dump_data;
    logic            dump_busy;
    logic            dump_done;

    modport slave (
        input  we0, we1, wa0, wa1, wd0, wd1, be0, be1, ra0, ra1, clr,
               dump_start, dump_ready,
        output rd0, rd1, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport master (
        output we0, we1, wa0, wa1, wd0, wd1, be0, be1, ra0, ra1, clr,
               dump_start, dump_ready,
        input  rd0, rd1, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  regfile_mp : 2W/2R byte-enabled register file with write bypass and a
//               handshaked register-dump engine
//  Rev 1.0
// ============================================================================
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    regfile_mp_if.slave      bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [DEPTH-1:0][DW-1:0] wmerge;
    logic [DW-1:0]            rd0_src, rd1_src;

    state_t                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic [DW-1:0]            ddata_q, ddata_d;

    // wmerge is each entry as it will look after this edge's writes; port 1
    // wins per byte, and it doubles as the same-cycle bypass source.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign wmerge[i][8*b +: 8] =
                (bus.we1 && (bus.wa1 == AW'(i)) && bus.be1[b]) ? bus.wd1[8*b +: 8] :
                (bus.we0 && (bus.wa0 == AW'(i)) && bus.be0[b]) ? bus.wd0[8*b +: 8] :
                                                                 mem_q[i][8*b +: 8];
        end
        assign mem_d[i] = (bus.clr || (ZERO_REG != 0 && i == 0)) ? '0 : wmerge[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd0_src = (BYPASS != 0) ? wmerge[bus.ra0] : mem_q[bus.ra0];
    assign rd1_src = (BYPASS != 0) ? wmerge[bus.ra1] : mem_q[bus.ra1];
    assign bus.rd0 = (ZERO_REG != 0 && bus.ra0 == '0) ? '0 : rd0_src;
    assign bus.rd1 = (ZERO_REG != 0 && bus.ra1 == '0) ? '0 : rd1_src;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ddata_q <= ddata_d;
        end
    end

    // Dump data is sampled from storage (not the bypass path) so later
    // writes to the captured entry cannot disturb a pending beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ddata_d = ddata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dump_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                ddata_d = (ZERO_REG != 0 && cnt_q == '0) ? '0 : mem_q[cnt_q];
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.dump_ready) begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dump_valid = (state_q == S_SEND);
    assign bus.dump_busy  = (state_q != S_IDLE);
    assign bus.dump_done  = (state_q == S_DONE);
    assign bus.dump_addr  = cnt_q;
    assign bus.dump_data  = ddata_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  tb_regfile_mp : directed testbench for regfile_mp (bypass and no-bypass)
//  Rev 1.0
// ============================================================================
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    regfile_mp_if #(.DW(DW), .AW(AW)) rif ();
    regfile_mp_if #(.DW(DW), .AW(AW)) bif ();

    regfile_mp #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (rif.slave)
    );

    regfile_mp #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif.slave)
    );

    assign bif.we0        = rif.we0;
    assign bif.we1        = rif.we1;
    assign bif.wa0        = rif.wa0;
    assign bif.wa1        = rif.wa1;
    assign bif.wd0        = rif.wd0;
    assign bif.wd1        = rif.wd1;
    assign bif.be0        = rif.be0;
    assign bif.be1        = rif.be1;
    assign bif.ra0        = rif.ra0;
    assign bif.ra1        = rif.ra1;
    assign bif.clr        = rif.clr;
    assign bif.dump_start = rif.dump_start;
    assign bif.dump_ready = rif.dump_ready;

    int n_pass = 0;
    int n_chk  = 0;
    logic [DW-1:0] model [DEPTH];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [3:0] b0, input logic e1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [3:0] b1);
        rif.we0 = e0; rif.wa0 = a0; rif.wd0 = d0; rif.be0 = b0;
        rif.we1 = e1; rif.wa1 = a1; rif.wd1 = d1; rif.be1 = b1;
    endtask

    // Advance one edge and apply the driven write to the reference model.
    task automatic commit();
        logic e0, e1, c;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [3:0] b0, b1;
        e0 = rif.we0; a0 = rif.wa0; d0 = rif.wd0; b0 = rif.be0;
        e1 = rif.we1; a1 = rif.wa1; d1 = rif.wd1; b1 = rif.be1;
        c  = rif.clr;
        step();
        rif.we0 = 1'b0; rif.we1 = 1'b0; rif.clr = 1'b0;
        if (c) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else begin
            if (e0 && a0 != 0)
                for (int b = 0; b < 4; b++) if (b0[b]) model[a0][8*b +: 8] = d0[8*b +: 8];
            if (e1 && a1 != 0)
                for (int b = 0; b < 4; b++) if (b1[b]) model[a1][8*b +: 8] = d1[8*b +: 8];
        end
    endtask

    task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [3:0] b0, input logic e1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic [3:0] b1);
        drv(e0, a0, d0, b0, e1, a1, d1, b1);
        commit();
    endtask

    task automatic start_dump();
        rif.dump_start = 1'b1;
        step();
        rif.dump_start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        rif.clr = 0; rif.dump_start = 0; rif.dump_ready = 0;
        rif.ra0 = 5; rif.ra1 = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #2;
        n_chk++; if (rif.dump_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", rif.dump_valid); else n_pass++;
        n_chk++; if (rif.dump_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", rif.dump_busy); else n_pass++;
        n_chk++; if (rif.dump_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", rif.dump_done); else n_pass++;
        n_chk++; if (rif.dump_addr !== 5'd0) $display("FAIL rst_addr: got %h expected 0", rif.dump_addr); else n_pass++;
        n_chk++; if (rif.dump_data !== 32'h0) $display("FAIL rst_data: got %h expected 0", rif.dump_data); else n_pass++;
        n_chk++; if (rif.rd0 !== 32'h0) $display("FAIL rst_rd0: got %h expected 0", rif.rd0); else n_pass++;
        rif.dump_start = 1'b1;
        step();
        rif.dump_start = 1'b0;
        n_chk++; if (rif.dump_busy !== 1'b0) $display("FAIL rst_start_ignored: got busy=%b expected 0", rif.dump_busy); else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_byte_write();
        wr(1, 5, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0);
        rif.ra0 = 5; #1;
        n_chk++; if (rif.rd0 !== 32'hDEADBEEF) $display("FAIL wr_full: got %h expected DEADBEEF", rif.rd0); else n_pass++;
        wr(0, 0, 0, 0, 1, 5, 32'h000000AA, 4'b0001);
        #1;
        n_chk++; if (rif.rd0 !== 32'hDEADBEAA) $display("FAIL wr_byte: got %h expected DEADBEAA", rif.rd0); else n_pass++;
    endtask

    task automatic test_same_addr();
        wr(1, 7, 32'h11111111, 4'b1111, 1, 7, 32'h22222222, 4'b0011);
        rif.ra0 = 7; #1;
        n_chk++; if (rif.rd0 !== 32'h11112222) $display("FAIL same_addr_r7: got %h expected 11112222", rif.rd0); else n_pass++;
        wr(1, 9, 32'hAABBCCDD, 4'b1010, 1, 9, 32'h11223344, 4'b0011);
        rif.ra1 = 9; #1;
        n_chk++; if (rif.rd1 !== 32'hAA003344) $display("FAIL same_addr_r9: got %h expected AA003344", rif.rd1); else n_pass++;
    endtask

    task automatic test_bypass();
        wr(1, 3, 32'hCAFEF00D, 4'b1111, 0, 0, 0, 0);
        drv(1, 3, 32'h12345678, 4'b1111, 0, 0, 0, 0);
        rif.ra1 = 3; #1;
        n_chk++; if (rif.rd1 !== 32'h12345678) $display("FAIL bypass_p0: got %h expected 12345678", rif.rd1); else n_pass++;
        n_chk++; if (bif.rd1 !== 32'hCAFEF00D) $display("FAIL nobypass_old: got %h expected CAFEF00D", bif.rd1); else n_pass++;
        rif.we1 = 1; rif.wa1 = 3; rif.wd1 = 32'h0000AB00; rif.be1 = 4'b0010; #1;
        n_chk++; if (rif.rd1 !== 32'h1234AB78) $display("FAIL bypass_prio: got %h expected 1234AB78", rif.rd1); else n_pass++;
        commit();
        n_chk++; if (bif.rd1 !== 32'h1234AB78) $display("FAIL nobypass_new: got %h expected 1234AB78", bif.rd1); else n_pass++;
    endtask

    task automatic test_zero_reg();
        drv(1, 0, 32'hFFFFFFFF, 4'b1111, 1, 0, 32'hFFFFFFFF, 4'b1111);
        rif.ra0 = 0; rif.ra1 = 0; #1;
        n_chk++; if (rif.rd0 !== 32'h0) $display("FAIL zero_bypass_rd0: got %h expected 0", rif.rd0); else n_pass++;
        n_chk++; if (rif.rd1 !== 32'h0) $display("FAIL zero_bypass_rd1: got %h expected 0", rif.rd1); else n_pass++;
        commit();
        n_chk++; if (rif.rd0 !== 32'h0) $display("FAIL zero_after: got %h expected 0", rif.rd0); else n_pass++;
        n_chk++; if (bif.rd0 !== 32'h0) $display("FAIL zero_after_nb: got %h expected 0", bif.rd0); else n_pass++;
    endtask

    task automatic test_clear();
        drv(1, 5, 32'h55555555, 4'b1111, 0, 0, 0, 0);
        rif.clr = 1'b1;
        commit();
        rif.ra0 = 5; rif.ra1 = 7; #1;
        n_chk++; if (rif.rd0 !== 32'h0) $display("FAIL clr_over_write: got %h expected 0", rif.rd0); else n_pass++;
        n_chk++; if (rif.rd1 !== 32'h0) $display("FAIL clr_r7: got %h expected 0", rif.rd1); else n_pass++;
        for (int i = 1; i < DEPTH; i++)
            wr(1, AW'(i), (32'h01010101 * i) ^ 32'hA5000000, 4'b1111, 0, 0, 0, 0);
    endtask

    task automatic test_dump_stream();
        int nbeat, ndone, last;
        bit fin;
        nbeat = 0; ndone = 0; last = 0; fin = 0;
        rif.dump_ready = 1'b1;
        start_dump();
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (rif.dump_valid) begin
                n_chk++; if (rif.dump_addr !== AW'(nbeat)) $display("FAIL dump_addr: got %0d expected %0d", rif.dump_addr, nbeat); else n_pass++;
                n_chk++; if (rif.dump_data !== model[nbeat]) $display("FAIL dump_data[%0d]: got %h expected %h", nbeat, rif.dump_data, model[nbeat]); else n_pass++;
                if (nbeat > 0) begin
                    n_chk++; if (cyc - last != 2) $display("FAIL dump_rate: got gap %0d expected 2", cyc - last); else n_pass++;
                end
                last = cyc;
                nbeat++;
            end
            if (rif.dump_done) ndone++;
            if (!rif.dump_busy) begin
                fin = 1;
                break;
            end
            step();
        end
        n_chk++; if (!fin) $display("FAIL dump_timeout: got busy=1 expected idle"); else n_pass++;
        n_chk++; if (nbeat != 32) $display("FAIL dump_beats: got %0d expected 32", nbeat); else n_pass++;
        n_chk++; if (ndone != 1) $display("FAIL dump_done_cnt: got %0d expected 1", ndone); else n_pass++;
    endtask

    task automatic test_dump_stall();
        bit found, fin;
        logic [DW-1:0] held;
        int ndone;
        found = 0; fin = 0; ndone = 0;
        rif.dump_ready = 1'b1;
        start_dump();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rif.dump_valid && rif.dump_addr == 5'd4) begin
                rif.dump_ready = 1'b0;
                found = 1;
                break;
            end
            step();
        end
        n_chk++; if (!found) $display("FAIL stall_reach: got no beat 4 expected beat 4"); else n_pass++;
        held = model[4];
        for (int k = 0; k < 5; k++) begin
            wr(1, 4, 32'h0BAD0000 + k, 4'b1111, 0, 0, 0, 0);
            n_chk++;
            if (rif.dump_valid !== 1'b1 || rif.dump_addr !== 5'd4 || rif.dump_data !== held)
                $display("FAIL stall_hold: got v=%b a=%0d d=%h expected v=1 a=4 d=%h",
                         rif.dump_valid, rif.dump_addr, rif.dump_data, held);
            else n_pass++;
        end
        rif.dump_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (rif.dump_done) ndone++;
            if (!rif.dump_busy) begin
                fin = 1;
                break;
            end
            step();
        end
        n_chk++; if (!fin || ndone != 1) $display("FAIL stall_finish: got fin=%0d done=%0d expected 1/1", fin, ndone); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        int ndone;
        found = 0; ndone = 0;
        rif.dump_ready = 1'b1;
        start_dump();
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rif.dump_valid && rif.dump_addr == 5'd10) begin
                found = 1;
                break;
            end
            step();
        end
        n_chk++; if (!found) $display("FAIL midrst_reach: got no beat 10 expected beat 10"); else n_pass++;
        rstn = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rif.ra0 = 5; rif.ra1 = 31; #1;
        n_chk++;
        if (rif.dump_valid !== 1'b0 || rif.dump_busy !== 1'b0 || rif.dump_done !== 1'b0 ||
            rif.dump_addr !== 5'd0 || rif.dump_data !== 32'h0)
            $display("FAIL midrst_outs: got v=%b b=%b d=%b a=%0d dat=%h expected all 0",
                     rif.dump_valid, rif.dump_busy, rif.dump_done, rif.dump_addr, rif.dump_data);
        else n_pass++;
        n_chk++; if (rif.rd0 !== 32'h0 || rif.rd1 !== 32'h0) $display("FAIL midrst_mem: got %h %h expected 0 0", rif.rd0, rif.rd1); else n_pass++;
        step();
        if (rif.dump_done) ndone++;
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (rif.dump_done || rif.dump_busy) ndone++;
        end
        n_chk++; if (ndone != 0) $display("FAIL midrst_nodone: got %0d activity cycles expected 0", ndone); else n_pass++;
        rif.ra0 = 7; rif.ra1 = 9; #1;
        n_chk++; if (rif.rd0 !== 32'h0 || rif.rd1 !== 32'h0) $display("FAIL midrst_after: got %h %h expected 0 0", rif.rd0, rif.rd1); else n_pass++;
    endtask

    task automatic test_after_reset();
        rstn = 1'b0;
        #1;
        step();
        rstn = 1'b1;
        drv(1, 12, 32'h0C0C0C0C, 4'b1111, 0, 0, 0, 0);
        rif.dump_start = 1'b1;
        commit();
        rif.dump_start = 1'b0;
        rif.ra0 = 12; #1;
        n_chk++; if (rif.rd0 !== 32'h0C0C0C0C) $display("FAIL first_edge_wr: got %h expected 0C0C0C0C", rif.rd0); else n_pass++;
        n_chk++; if (rif.dump_busy !== 1'b1) $display("FAIL first_edge_start: got busy=%b expected 1", rif.dump_busy); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_write();
        test_same_addr();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_dump_stream();
        test_dump_stall();
        test_reset_mid();
        test_after_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 5, address width; depth SHALL be DEPTH = 2**AW.
REQ-003 Parameter ZERO_REG, default 1; when 1, entry 0 SHALL be hardwired to zero.
REQ-004 Parameter BYPASS, default 1; when 1, same-cycle write-to-read forwarding SHALL be enabled.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
 - clk  in  1  single clock, rising edge.
 - rstn  in  1  asynchronous, active-low reset.
 - we0, we1  in  1 each  write enables for write ports 0 and 1.
 - wa0, wa1  in  AW each  write addresses.
 - wd0, wd1  in  DW each  write data.
 - be0, be1  in  DW/8 each  byte enables.
 - ra0, ra1  in  AW each  read addresses.
 - rd0, rd1  out  DW each  read data.
 - clr  in  1  synchronous clear of all entries.
 - dump_start  in  1  start pulse for a register dump.
 - dump_valid  out  1  dump beat valid.
 - dump_ready  in  1  dump beat accept.
 - dump_addr  out  AW  address of the current dump beat.
 - dump_data  out  DW  data of the current dump beat.
 - dump_busy  out  1  dump engine active.
 - dump_done  out  1  one-cycle pulse when the dump completes.

Function
REQ-006 Writes SHALL take effect at the rising clk edge; only bytes whose be bit is 1 SHALL be updated.
REQ-007 When both ports write the same address in the same cycle, port 1 SHALL win per byte wherever be1=1; port 0 bytes SHALL apply wherever be1=0 and be0=1.
REQ-008 When ZERO_REG=1, writes to address 0 SHALL be discarded, and rd0/rd1 SHALL return 0 for address 0.
REQ-009 Reads SHALL be combinational, with zero-cycle latency.
REQ-010 When BYPASS=1, rd SHALL return the stored word merged with this cycle's pending write bytes to the same address, applying REQ-007 priority; address 0 with ZERO_REG=1 SHALL still read 0.
REQ-011 When BYPASS=0, rd SHALL return the pre-edge stored value.
REQ-012 clr=1 SHALL zero all entries at the edge; clr SHALL override any same-cycle write.
REQ-013 The dump FSM SHALL have states IDLE, LOAD, SEND and DONE.
REQ-014 IDLE -> LOAD on dump_start=1, with the address counter set to 0; dump_start SHALL be ignored in all other states.
REQ-015 In LOAD, dump_data SHALL be registered from the stored entry at the counter address (0 for address 0 when ZERO_REG=1, no bypass), and the FSM SHALL go to SEND.
REQ-016 In SEND, dump_valid=1 and dump_addr/dump_data SHALL remain stable until dump_valid & dump_ready.
REQ-017 A write to the captured address while in SEND SHALL NOT alter dump_data.
REQ-018 On handshake in SEND: if counter = DEPTH-1, go to DONE; otherwise increment the counter and go to LOAD.
REQ-019 Throughput SHALL be one beat every 2 cycles when dump_ready is held at 1.
REQ-020 DONE SHALL assert dump_done for exactly one cycle, then return to IDLE.
REQ-021 dump_busy SHALL be 1 in LOAD, SEND and DONE.
REQ-022 clr during a dump SHALL NOT abort the dump; later LOADs SHALL capture zeros.

Reset
REQ-023 rstn=0 SHALL asynchronously clear all entries to 0, set the FSM to IDLE and the counter to 0.
REQ-024 During reset, dump_valid, dump_busy, dump_done, dump_addr and dump_data SHALL be 0.
REQ-025 Reset asserted mid-dump SHALL abandon the dump with no dump_done pulse.
REQ-026 After rstn deasserts, the block SHALL accept writes and dump_start from the first rising edge.

Verification
REQ-027 Write r5=0xDEADBEEF with be0=4'b1111, then write via port 1 with wd1=0x000000AA, be1=4'b0001 -> rd0 with ra0=5 reads 0xDEADBEAA.
REQ-028 Same cycle: we0 to r7 with 0x11111111, we1 to r7 with 0x22222222, be1=4'b0011, both be0 bits all 1 -> r7=0x11112222.
REQ-029 BYPASS=1: ra1=3 while writing r3=0x12345678 -> rd1=0x12345678 in the same cycle; BYPASS=0 -> rd1 shows the old value.
REQ-030 Write r0=0xFFFFFFFF with ZERO_REG=1 -> rd0 with ra0=0 reads 0, and the dump beat for address 0 carries 0.
REQ-031 dump_start with dump_ready=1 -> 32 beats at addresses 0..31, one every 2 cycles, then a single dump_done pulse.
REQ-032 dump_ready=0 for 5 cycles while writing the captured address -> dump_data is unchanged.
REQ-033 rstn pulsed low at beat 10 -> all outputs 0, no dump_done, all entries read 0.
